// File: rtl/comparator_seq.sv
// comparator_seq: multi-cycle magnitude comparator.
// Compares two WIDTH-bit operands MSB-first, CHUNK bits per clock, and stops
// at the first differing chunk. Signed compares are handled by flipping the
// sign bit of both operands at capture (offset binary), so the chunk datapath
// is always unsigned.
// Optional build macro COMPARATOR_SEQ_STATS_EN adds saturating result counters
// (cnt_great / cnt_equal / cnt_less) with a synchronous clr_stats.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | waiting for start; results hold their last value
//   RUN    | comparing chunk idx; exits early on the first difference
//   DONE   | done pulse; results valid and one-hot

module comparator_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
`ifdef COMPARATOR_SEQ_STATS_EN
    input  logic             clr_stats,
    output logic [CNT_W-1:0] cnt_great,
    output logic [CNT_W-1:0] cnt_equal,
    output logic [CNT_W-1:0] cnt_less,
`endif
    output logic             busy,
    output logic             done,
    output logic             great,
    output logic             equal,
    output logic             less
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [WIDTH-1:0] SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    generate
        if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0 || CNT_W < 1) begin : g_param_check
            $error("comparator_seq: WIDTH must be >= 2 and a multiple of CHUNK; CNT_W must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [IDX_W-1:0]   idx_q;
    logic [CHUNK-1:0]   chunk_a;
    logic [CHUNK-1:0]   chunk_b;
    logic               chunk_diff;
    logic               last_chunk;

    assign chunk_a    = a_q[idx_q*CHUNK +: CHUNK];
    assign chunk_b    = b_q[idx_q*CHUNK +: CHUNK];
    assign chunk_diff = (chunk_a != chunk_b);
    assign last_chunk = (idx_q == '0);

    // State register; reset aborts any compare in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: early exit on a differing chunk, else walk down to chunk 0.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_RUN;
            S_RUN:  if (chunk_diff || last_chunk) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    // Operand capture, chunk index and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            idx_q <= '0;
            great <= 1'b0;
            equal <= 1'b0;
            less  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q   <= data1 ^ (signed_mode ? SIGN_MASK : '0);
                        b_q   <= data2 ^ (signed_mode ? SIGN_MASK : '0);
                        idx_q <= IDX_W'(N - 1);
                    end
                end
                S_RUN: begin
                    if (chunk_diff) begin
                        great <= (chunk_a > chunk_b);
                        less  <= (chunk_a < chunk_b);
                        equal <= 1'b0;
                    end else if (last_chunk) begin
                        great <= 1'b0;
                        less  <= 1'b0;
                        equal <= 1'b1;
                    end else begin
                        idx_q <= idx_q - IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef COMPARATOR_SEQ_STATS_EN
    // Saturating result counters; clr_stats wins over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_great <= '0;
            cnt_equal <= '0;
            cnt_less  <= '0;
        end else if (clr_stats) begin
            cnt_great <= '0;
            cnt_equal <= '0;
            cnt_less  <= '0;
        end else if (state_q == S_DONE) begin
            if (great && cnt_great != '1) cnt_great <= cnt_great + CNT_W'(1);
            if (equal && cnt_equal != '1) cnt_equal <= cnt_equal + CNT_W'(1);
            if (less  && cnt_less  != '1) cnt_less  <= cnt_less  + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_comparator_seq.sv
// Testbench for comparator_seq (WIDTH=16, CHUNK=4). Expected results come from
// plain integer comparison; expected latency from locating the first differing
// nibble from the top.
`timescale 1ns/1ps

module tb_comparator_seq;

    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic             busy, done, great, equal, less;
`ifdef COMPARATOR_SEQ_STATS_EN
    logic             clr_stats;
    logic [CNT_W-1:0] cnt_great, cnt_equal, cnt_less;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    comparator_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .data1       (data1),
        .data2       (data2),
`ifdef COMPARATOR_SEQ_STATS_EN
        .clr_stats   (clr_stats),
        .cnt_great   (cnt_great),
        .cnt_equal   (cnt_equal),
        .cnt_less    (cnt_less),
`endif
        .busy        (busy),
        .done        (done),
        .great       (great),
        .equal       (equal),
        .less        (less)
    );

    always #5 clk = ~clk;

    // Reference: result as {great,equal,less} from integer compare.
    function automatic logic [2:0] ref_result(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic sm);
        int ia, ib;
        if (sm) begin
            ia = int'($signed(a));
            ib = int'($signed(b));
        end else begin
            ia = int'({16'd0, a});
            ib = int'({16'd0, b});
        end
        if (ia > ib)       return 3'b100;
        else if (ia == ib) return 3'b010;
        else               return 3'b001;
    endfunction

    // Reference: number of chunks examined before the result is known.
    function automatic int ref_latency(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        for (int c = N - 1; c >= 0; c--) begin
            if (a[c*CHUNK +: CHUNK] != b[c*CHUNK +: CHUNK]) return N - c;
        end
        return N;
    endfunction

    // Drives one compare and observes it. lat = negedges after the accepting
    // edge until done is seen; busy_cnt counts busy cycles up to and including done.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sm,
                          output int lat, output logic [2:0] res, output int busy_cnt,
                          output logic timed_out);
        @(negedge clk);
        start = 1'b1; data1 = a; data2 = b; signed_mode = sm;
        @(posedge clk);
        lat = -1; busy_cnt = 0; timed_out = 1'b1; res = 3'b000;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (j == 0) begin
                start = 1'b0;
                data1 = $urandom; data2 = $urandom; signed_mode = $urandom_range(0, 1);
            end
            if (busy) busy_cnt++;
            if (done) begin
                lat = j; res = {great, equal, less}; timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; signed_mode = 1'b0; data1 = '0; data2 = '0;
`ifdef COMPARATOR_SEQ_STATS_EN
        clr_stats = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, done, great, equal, less} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 00000", {busy, done, great, equal, less});
        end
    endtask

    task automatic test_directed;
        int lat, bc; logic [2:0] res; logic to;
        // 0x1234 vs 0x1235 unsigned: differ in lowest chunk
        run_op(16'h1234, 16'h1235, 1'b0, lat, res, bc, to);
        n_cmp++; if (to !== 1'b0 || res !== 3'b001) begin n_fail++;
            $display("FAIL low_chunk_less: got gel=%b to=%b want 001", res, to); end
        n_cmp++; if (lat !== 4) begin n_fail++;
            $display("FAIL low_chunk_latency: got %0d want 4", lat); end
        n_cmp++; if (bc !== 5) begin n_fail++;
            $display("FAIL low_chunk_busy_cycles: got %0d want 5", bc); end
        // 0xA000 vs 0x1000: early exit both modes
        run_op(16'hA000, 16'h1000, 1'b0, lat, res, bc, to);
        n_cmp++; if (res !== 3'b100 || lat !== 1) begin n_fail++;
            $display("FAIL early_unsigned: got gel=%b lat=%0d want 100 lat=1", res, lat); end
        run_op(16'hA000, 16'h1000, 1'b1, lat, res, bc, to);
        n_cmp++; if (res !== 3'b001 || lat !== 1) begin n_fail++;
            $display("FAIL early_signed: got gel=%b lat=%0d want 001 lat=1", res, lat); end
        // equal operands in both modes
        run_op(16'hBEEF, 16'hBEEF, 1'b0, lat, res, bc, to);
        n_cmp++; if (res !== 3'b010 || lat !== 4) begin n_fail++;
            $display("FAIL equal_unsigned: got gel=%b lat=%0d want 010 lat=4", res, lat); end
        run_op(16'hBEEF, 16'hBEEF, 1'b1, lat, res, bc, to);
        n_cmp++; if (res !== 3'b010 || lat !== 4) begin n_fail++;
            $display("FAIL equal_signed: got gel=%b lat=%0d want 010 lat=4", res, lat); end
        // -1 vs 0 signed
        run_op(16'hFFFF, 16'h0000, 1'b1, lat, res, bc, to);
        n_cmp++; if (res !== 3'b001 || lat !== 1) begin n_fail++;
            $display("FAIL signed_minus1: got gel=%b lat=%0d want 001 lat=1", res, lat); end
    endtask

    task automatic test_handshake;
        int n_done;
        @(negedge clk);
        start = 1'b1; data1 = 16'd5; data2 = 16'd3; signed_mode = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b1; data1 = 16'd1; data2 = 16'd9;  // must be ignored while busy
        @(negedge clk);
        start = 1'b0;
        n_done = 0;
        for (int j = 0; j < 12; j++) begin
            if (done) n_done++;
            @(negedge clk);
        end
        n_cmp++; if (n_done !== 1) begin n_fail++;
            $display("FAIL handshake_single_done: got %0d pulses want 1", n_done); end
        n_cmp++; if ({great, equal, less} !== 3'b100 || busy !== 1'b0) begin n_fail++;
            $display("FAIL handshake_hold: got gel=%b busy=%b want 100 busy=0", {great, equal, less}, busy); end
        // next accepted compare: results hold until its done
        start = 1'b1; data1 = 16'd1; data2 = 16'd9;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n_cmp++; if ({great, equal, less} !== 3'b100 || busy !== 1'b1) begin n_fail++;
            $display("FAIL handshake_not_cleared_on_start: got gel=%b busy=%b want 100 busy=1",
                     {great, equal, less}, busy); end
        for (int j = 0; j < 20 && !done; j++) @(negedge clk);
        n_cmp++; if (done !== 1'b1 || {great, equal, less} !== 3'b001) begin n_fail++;
            $display("FAIL handshake_second: got done=%b gel=%b want done=1 gel=001", done, {great, equal, less}); end
        @(negedge clk);
    endtask

    task automatic test_reset_midrun;
        int n_done; int lat, bc; logic [2:0] res; logic to;
        @(negedge clk);
        start = 1'b1; data1 = 16'h0001; data2 = 16'h0002; signed_mode = 1'b0;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++; if ({busy, done, great, equal, less} !== 5'b0) begin n_fail++;
            $display("FAIL reset_midrun_outputs: got %b want 00000", {busy, done, great, equal, less}); end
        @(posedge clk);
        @(negedge clk); rst = 1'b0;
        n_done = 0;
        for (int j = 0; j < 8; j++) begin
            if (done || busy) n_done++;
            @(negedge clk);
        end
        n_cmp++; if (n_done !== 0) begin n_fail++;
            $display("FAIL reset_midrun_no_done: got %0d active cycles want 0", n_done); end
        run_op(16'h0001, 16'h0002, 1'b0, lat, res, bc, to);
        n_cmp++; if (to !== 1'b0 || res !== 3'b001 || lat !== 4) begin n_fail++;
            $display("FAIL reset_midrun_recover: got gel=%b lat=%0d want 001 lat=4", res, lat); end
    endtask

    task automatic test_random;
        int lat, bc; logic [2:0] res; logic to;
        logic [WIDTH-1:0] a, b; logic sm;
        for (int i = 0; i < 40; i++) begin
            a  = WIDTH'($urandom);
            sm = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = a ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
                default: b = WIDTH'($urandom);
            endcase
            run_op(a, b, sm, lat, res, bc, to);
            n_cmp++; if (to !== 1'b0 || res !== ref_result(a, b, sm) || lat !== ref_latency(a, b)
                         || bc !== lat + 1) begin n_fail++;
                $display("FAIL random_%0d: a=%h b=%h sm=%b got gel=%b lat=%0d busy=%0d to=%b want gel=%b lat=%0d",
                         i, a, b, sm, res, lat, bc, to, ref_result(a, b, sm), ref_latency(a, b)); end
        end
    endtask

`ifdef COMPARATOR_SEQ_STATS_EN
    task automatic test_stats;
        int lat, bc; logic [2:0] res; logic to;
        @(negedge clk); clr_stats = 1'b1;
        @(negedge clk); clr_stats = 1'b0;
        for (int i = 0; i < 4; i++) run_op(16'h8000 + 16'(i), 16'h0001, 1'b0, lat, res, bc, to);
        @(negedge clk);
        n_cmp++; if (cnt_great !== 2'd3 || cnt_equal !== 2'd0 || cnt_less !== 2'd0) begin n_fail++;
            $display("FAIL stats_saturate: got g=%0d e=%0d l=%0d want 3 0 0", cnt_great, cnt_equal, cnt_less); end
        run_op(16'h1111, 16'h1111, 1'b0, lat, res, bc, to);
        clr_stats = 1'b1;   // coincident with the done cycle
        @(negedge clk); clr_stats = 1'b0;
        n_cmp++; if (cnt_great !== 2'd0 || cnt_equal !== 2'd0 || cnt_less !== 2'd0) begin n_fail++;
            $display("FAIL stats_clear_priority: got g=%0d e=%0d l=%0d want 0 0 0", cnt_great, cnt_equal, cnt_less); end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_handshake();
        test_reset_midrun();
        test_random();
`ifdef COMPARATOR_SEQ_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/comparator_seq.md
Name: comparator_seq

Overview:
Parametrised, multi-cycle magnitude comparator that succeeds the fixed 4-bit combinational comparator. It compares two WIDTH-bit operands MSB-first, CHUNK bits per clock, and terminates early on the first differing chunk. Signed or unsigned mode is selected per operation. A start/busy/done handshake lets wide compares share a datapath slot without long combinational paths.

Parameters:
WIDTH, 16, operand width in bits; must be >= 2.
CHUNK, 4, bits examined per cycle; must divide WIDTH exactly.
CNT_W, 16, width of each statistics counter (used only with the optional feature).

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
start  input  1  request a compare; accepted only when busy=0
signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start
data1  input  WIDTH  operand A; sampled with start
data2  input  WIDTH  operand B; sampled with start
busy  output  1  high while the block is not IDLE
done  output  1  one-cycle pulse: result valid
great  output  1  A > B
equal  output  1  A == B
less  output  1  A < B

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset: state=IDLE; busy, done, great, equal and less all 0; chunk index 0. Reset mid-operation aborts the compare immediately, with no done pulse.
- Let N = WIDTH/CHUNK.
- States:
  - IDLE: start=1 at an edge captures data1, data2 and signed_mode into registers; moves to RUN; index = N-1.
  - RUN: each edge compares the chunk at the index (bits [idx*CHUNK +: CHUNK]) unsigned.
    - Chunks differ: set great/less from that chunk, clear equal, go to DONE.
    - Chunks equal and idx==0: set equal=1, great=less=0, go to DONE.
    - Otherwise idx decrements.
  - DONE: done=1 for exactly this one cycle; returns to IDLE at the next edge.
- busy = (state != IDLE). start is ignored while busy=1, including in the DONE cycle. Operand changes while busy have no effect.
- Signed mode: at capture, invert bit WIDTH-1 of both operands (offset-binary). The unsigned chunk compare then yields the correct signed result.
- Result outputs:
  - great, equal and less are registered and one-hot whenever done=1.
  - They hold their last value until the next result is written; they are not cleared on start.
- Latency: if k = number of chunks examined (1..N), done is high in the cycle following the k-th edge after the accepting edge. Best case is 1 chunk; worst case is N, taken for equal operands or a difference in the lowest chunk.
- Back-to-back operation: the earliest next acceptance is the edge ending the DONE cycle plus one, i.e. the first IDLE cycle.

Optional Feature:
- Macro: COMPARATOR_SEQ_STATS_EN.
- Defined:
  - Adds ports clr_stats (input, 1) and cnt_great, cnt_equal, cnt_less (outputs, CNT_W each).
  - On each done pulse, the counter matching the result increments and saturates at all-ones.
  - clr_stats=1 zeroes all three counters synchronously; it takes priority over an increment in the same cycle.
  - rst zeroes all three counters asynchronously.
- Undefined: these ports and counters do not exist; core behaviour is identical.

Test Plan:
- Unsigned, WIDTH=16, CHUNK=4: A=0x1234, B=0x1235 -> less=1, great=0, equal=0; done 4 cycles after acceptance; busy high for 5 cycles (4 RUN cycles plus the DONE cycle).
- Unsigned: A=0xA000, B=0x1000 -> great=1, done 1 cycle after acceptance (early exit). Same operands with signed_mode=1 (A = -24576, B = 4096) -> less=1, also after 1 cycle.
- Equal operands: A=B=0xBEEF in signed and unsigned mode -> equal=1 after 4 cycles. Also signed A=0xFFFF (-1), B=0x0000 -> less=1.
- Handshake: pulse start with A=5, B=3; pulse start again with A=1, B=9 while busy -> second request ignored; a single done with great=1. Outputs hold great=1 until the next accepted compare completes.
- Reset mid-run: A=0x0001, B=0x0002 accepted, assert rst after 2 cycles -> busy, done and all results 0 at once. No done pulse follows; a new compare then works normally.
- With COMPARATOR_SEQ_STATS_EN and CNT_W=2: run 4 great compares -> cnt_great saturates at 3. clr_stats coincident with a done -> all counters read 0.
